// File: rtl/axby_host_master_if.sv
// rtl/axby_host_master_if.sv - request/response ports and coprocessor bus of axby_host_master
interface axby_host_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_x;
    logic [7:0]  req_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic        WR_b;
    logic        RD_b;
    logic [7:0]  inx;
    logic [7:0]  iny;
    logic        RDYP;
    logic [15:0] dataIn;

    modport master (
        input  req_valid, req_x, req_y, rsp_ready, RDYP, dataIn,
        output req_ready, rsp_valid, rsp_data, rsp_timeout, WR_b, RD_b, inx, iny
    );

    modport slave (
        output req_valid, req_x, req_y, rsp_ready, RDYP, dataIn,
        input  req_ready, rsp_valid, rsp_data, rsp_timeout, WR_b, RD_b, inx, iny
    );
endinterface

// File: rtl/axby_host_master.sv
// rtl/axby_host_master.sv - AXBY host initiator: write x/y, wait for RDYP, read 16-bit result
module axby_host_master #(
    parameter int STROBE_LEN = 2,
    parameter int GAP_LEN    = 1,
    parameter int TIMEOUT    = 1023
) (
    input logic              clk,
    input logic              reset,
    axby_host_master_if.master bus
);
    localparam int CNT_MAX = (STROBE_LEN > GAP_LEN) ? STROBE_LEN : GAP_LEN;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STROBE_LEN - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LEN - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_SAT   = TW'(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, WRX, GAP1, WRY, GAP2, WAIT_LO, WAIT_HI, RDH, GAP3, RDL, RESP
    } state_t;

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_tcnt;
    logic        r_rdy_m, r_rdy_s;
    logic        r_wr_b, r_rd_b;
    logic [7:0]  r_inx, r_iny;
    logic        r_rsp_valid, r_rsp_timeout;
    logic [15:0] r_rsp_data;

    logic w_stb_done, w_gap_done, w_to;
    assign w_stb_done = (r_cnt == STB_LAST);
    assign w_gap_done = (r_cnt == GAP_LAST);
    // >= so a ready-low win on the final cycle still times out in WAIT_HI
    assign w_to       = (r_tcnt >= TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_tcnt        <= '0;
            r_rdy_m       <= 1'b0;
            r_rdy_s       <= 1'b0;
            r_wr_b        <= 1'b1;
            r_rd_b        <= 1'b1;
            r_inx         <= 8'h00;
            r_iny         <= 8'h00;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_data    <= 16'h0000;
        end else begin
            r_rdy_m <= bus.RDYP;
            r_rdy_s <= r_rdy_m;
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_inx   <= bus.req_x;
                    r_iny   <= bus.req_y;
                    r_wr_b  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= WRX;
                end
                WRX: if (w_stb_done) begin
                    r_wr_b  <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= GAP1;
                end else r_cnt <= r_cnt + 1'b1;
                GAP1: if (w_gap_done) begin
                    r_wr_b  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= WRY;
                end else r_cnt <= r_cnt + 1'b1;
                WRY: if (w_stb_done) begin
                    r_wr_b  <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= GAP2;
                end else r_cnt <= r_cnt + 1'b1;
                GAP2: if (w_gap_done) begin
                    r_tcnt  <= '0;
                    r_state <= WAIT_LO;
                end else r_cnt <= r_cnt + 1'b1;
                WAIT_LO: begin
                    if (!r_rdy_s) r_state <= WAIT_HI;
                    else if (w_to) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_data    <= 16'h0000;
                        r_state       <= RESP;
                    end
                    if (r_tcnt != TO_SAT) r_tcnt <= r_tcnt + 1'b1;
                end
                WAIT_HI: begin
                    if (r_rdy_s) begin
                        r_rd_b  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= RDH;
                    end else if (w_to) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_data    <= 16'h0000;
                        r_state       <= RESP;
                    end
                    if (r_tcnt != TO_SAT) r_tcnt <= r_tcnt + 1'b1;
                end
                RDH: if (w_stb_done) begin
                    r_rsp_data[15:8] <= bus.dataIn[15:8];
                    r_rd_b  <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= GAP3;
                end else r_cnt <= r_cnt + 1'b1;
                GAP3: if (w_gap_done) begin
                    r_rd_b  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= RDL;
                end else r_cnt <= r_cnt + 1'b1;
                RDL: if (w_stb_done) begin
                    r_rsp_data[7:0] <= bus.dataIn[7:0];
                    r_rd_b        <= 1'b1;
                    r_rsp_valid   <= 1'b1;
                    r_rsp_timeout <= 1'b0;
                    r_state       <= RESP;
                end else r_cnt <= r_cnt + 1'b1;
                RESP: if (bus.rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = (r_state == IDLE);
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.WR_b        = r_wr_b;
    assign bus.RD_b        = r_rd_b;
    assign bus.inx         = r_inx;
    assign bus.iny         = r_iny;
endmodule

// File: doc/axby_host_master.md
Name: axby_host_master

Overview:
- Host-side initiator for the AXBY coprocessor bus; this is the master that drives WR_b/RD_b into the coprocessor interface FSM.
- Accepts one (x, y) request on a valid/ready port and writes x then y with two write strobes.
- Waits for the coprocessor ready flag RDYP, then reads the 16-bit result with two read strobes (high half, then low half).
- Returns the result, or a timeout flag, on a valid/ready response port.

Parameters:
- STROBE_LEN, 2, cycles each WR_b/RD_b strobe is held low (>=1)
- GAP_LEN, 1, cycles strobes stay high between consecutive strobes (>=1)
- TIMEOUT, 1023, max cycles spent in ready-wait before abort (>=4)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_x  in  8  operand x
- req_y  in  8  operand y
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  16  result {high byte, low byte}
- rsp_timeout  out  1  response is an abort, rsp_data=0
- WR_b  out  1  active-low write strobe to coprocessor
- RD_b  out  1  active-low read strobe to coprocessor
- inx  out  8  x bus to coprocessor
- iny  out  8  y bus to coprocessor
- RDYP  in  1  coprocessor ready, asynchronous to this block's logic timing
- dataIn  in  16  coprocessor result bus

Behaviour:
- Reset values: WR_b=1, RD_b=1, inx=0, iny=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, FSM=IDLE. Reset mid-transaction aborts immediately; no response is produced.
- All outputs are registered except req_ready, which is (state==IDLE).
- RDYP passes through a 2-flop synchronizer (rdy_s, 2-cycle latency) and is reset to 0. All ready decisions use rdy_s only.
- States, in order:
  - IDLE: on req_valid&&req_ready, latch req_x into inx and req_y into iny, go to WRX. inx/iny hold until the next accept.
  - WRX: WR_b=0 for STROBE_LEN cycles. This write loads x.
  - GAP1: WR_b=1 for GAP_LEN cycles.
  - WRY: WR_b=0 for STROBE_LEN cycles. This write loads y.
  - GAP2: GAP_LEN cycles.
  - WAIT_LO: wait for rdy_s==0, i.e. the previous ready has been cleared by the start.
  - WAIT_HI: wait for rdy_s==1.
  - RDH: RD_b=0 for STROBE_LEN cycles. On the last cycle, capture dataIn[15:8] into rsp_data[15:8].
  - GAP3: GAP_LEN cycles.
  - RDL: RD_b=0 for STROBE_LEN cycles. On the last cycle, capture dataIn[7:0] into rsp_data[7:0].
  - RESP: rsp_valid=1. Hold rsp_data and rsp_timeout stable until rsp_valid&&rsp_ready, then return to IDLE and clear rsp_valid.
- WR_b and RD_b are never low in the same cycle. Each strobe is exactly STROBE_LEN cycles long, and the gap between strobes is at least GAP_LEN cycles.
- Timeout counter:
  - Clears on entry to WAIT_LO and counts every cycle in WAIT_LO and WAIT_HI.
  - When the count reaches TIMEOUT, go to RESP with rsp_timeout=1 and rsp_data=16'h0000. No read strobes are issued.
  - If the ready condition and the timeout occur in the same cycle, the ready condition wins.
- A new request is not accepted while a response is pending. There is no request buffering.
- The strobe/gap counter uses clog2(max(STROBE_LEN,GAP_LEN)+1) bits. The timeout counter uses clog2(TIMEOUT+1) bits and does not wrap.

Test Plan:
- Reset, then idle 10 cycles -> WR_b=RD_b=1, inx=iny=0, req_ready=1, rsp_valid=0.
- Request x=8'h05, y=8'h03; responder model drops RDYP 3 cycles after the second WR and raises it 20 cycles later with dataIn=16'h1234 -> exactly two WR pulses of 2 cycles each, inx=05 and iny=03 throughout, two RD pulses, rsp_data=16'h1234, rsp_timeout=0.
- RDYP stuck high (never clears), TIMEOUT=1023 -> rsp_valid with rsp_timeout=1 and rsp_data=0 exactly 1023 cycles after WAIT_LO entry; RD_b stays 1.
- rsp_ready held 0 for 15 cycles after rsp_valid -> rsp_data and rsp_valid stable, req_ready=0; WR_b/RD_b stay high; returns to IDLE one cycle after the handshake.
- Assert reset during WAIT_HI -> next cycle WR_b=RD_b=1 and inx=0. A fresh request x=8'hFF, y=8'h01 then completes normally with dataIn=16'hABCD, giving rsp_data=16'hABCD.
- Back-to-back requests with req_valid held high and rsp_ready=1 -> second accept occurs one cycle after the first response handshake; strobe spacing is >=GAP_LEN and WR_b/RD_b are never low together.
